// File: rtl/rv_regfile_sb.sv
// RV32I integer register file with load scoreboard, sub-word load
// extraction and optional same-cycle write-to-read bypass.
module rv_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [1:0]          wr_sel,
    input  logic [XLEN-1:0]     wr_alu,
    input  logic [XLEN-1:0]     wr_lui_imm,
    input  logic [XLEN-1:0]     wr_link,
    input  logic [XLEN-1:0]     wr_load,
    input  logic [1:0]          ld_size,
    input  logic                ld_unsigned,
    input  logic [1:0]          ld_off,
    input  logic                ld_issue,
    input  logic [AW-1:0]       ld_issue_rd,
    output logic                sb_err
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_LUI  = 2'd2;
    localparam logic [1:0] SEL_LINK = 2'd3;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             err_q, err_d;

    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [XLEN-1:0]  ld_val;
    logic [XLEN-1:0]  wr_val;
    logic             wr_is_load;
    logic             wr_live;

    assign wr_is_load = wr_en & (wr_sel == SEL_LOAD);
    assign wr_live    = wr_en & (wr_addr != '0);

    // Pick the addressed lane and extend it, then mux the write source.
    always_comb begin
        lane_b = wr_load[{ld_off, 3'b000} +: 8];
        lane_h = wr_load[{ld_off[1], 4'b0000} +: 16];
        case (ld_size)
            2'd0:    ld_val = {{(XLEN-8){~ld_unsigned & lane_b[7]}}, lane_b};
            2'd1:    ld_val = {{(XLEN-16){~ld_unsigned & lane_h[15]}}, lane_h};
            default: ld_val = wr_load;
        endcase
        case (wr_sel)
            SEL_ALU:  wr_val = wr_alu;
            SEL_LOAD: wr_val = ld_val;
            SEL_LUI:  wr_val = wr_lui_imm;
            SEL_LINK: wr_val = wr_link;
            default:  wr_val = wr_alu;
        endcase
    end

    // Scoreboard next state: a new issue wins over a returning load.
    always_comb begin
        busy_d = busy_q;
        if (wr_is_load)
            busy_d[wr_addr] = 1'b0;
        if (ld_issue)
            busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
        err_d = wr_is_load & (wr_addr != '0) & ~busy_q[wr_addr];
    end

    // Register storage; x0 stays zero because it is never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_val;
        end
    end

    // Scoreboard bits and the error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign sb_err = err_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        assign ra  = rd_addr[k*AW +: AW];
        assign hit = (BYPASS != 0) & wr_en & (wr_addr == ra);
        assign rd_data[k*XLEN +: XLEN] = (ra == '0) ? '0 :
                                         hit ? wr_val : regs_q[ra];
        assign rd_busy[k] = busy_q[ra] & ~(hit & wr_is_load);
    end

endmodule

// File: doc/rv_regfile_sb.md
# rv_regfile_sb

Parametrised RV32I integer register file with an integrated load scoreboard, sub-word load extraction and optional write-to-read bypass. It sits between the decode stage, which reads operands and issues loads, and the write-back stage, which retires ALU, load, LUI and link results. It replaces the single-write-source register file with a write-source mux, NRD read ports and per-register pending-load tracking, so the core can detect load-use hazards.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count (power of two); AW = $clog2(NREGS)
- NRD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data (combinational)
- rd_busy  out  NRD  register targeted by port k has a load outstanding
- wr_en  in  1  write-back valid
- wr_addr  in  AW  destination register
- wr_sel  in  2  write source: 0 = ALU, 1 = LOAD, 2 = LUI, 3 = LINK
- wr_alu, wr_lui_imm, wr_link, wr_load  in  XLEN each  source values; wr_load is the raw aligned memory word
- ld_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- ld_unsigned  in  1  zero-extend when set, else sign-extend
- ld_off  in  2  byte offset within wr_load
- ld_issue  in  1  a load to ld_issue_rd is issued this cycle
- ld_issue_rd  in  AW  load destination
- sb_err  out  1  registered one-cycle pulse: load returned to a non-busy register

## Operation
- Storage: NREGS x XLEN flops; busy[NREGS] scoreboard bits. Register x0 reads 0 and is never written. busy[0] is constantly 0.
- Write value: selected by wr_sel. For LOAD:
  - Byte: lane wr_load[8*ld_off +: 8].
  - Half: lane wr_load[16*ld_off[1] +: 16]; ld_off[0] is ignored.
  - Word: the whole word; ld_off is ignored.
  - Byte and half lanes are extended to XLEN per ld_unsigned.
- Commit: when wr_en and wr_addr != 0, the write value is written at the clock edge. The write happens regardless of busy state, since WAW ordering is the core's responsibility.
- Scoreboard, per register r != 0, with set = ld_issue & ld_issue_rd == r and clr = wr_en & wr_sel == LOAD & wr_addr == r:
  - set only: busy <= 1.
  - clr only: busy <= 0.
  - set and clr in the same cycle: busy stays 1, because the new load supersedes the returning one.
  - Neither: hold.
- sb_err: next-cycle value = wr_en & wr_sel == LOAD & wr_addr != 0 & ~busy[wr_addr]. The pulse is informational only; the write still commits.
- Reads, per port k:
  - rd_data = 0 if the address is 0.
  - Otherwise, if BYPASS and wr_en and wr_addr == rd_addr, rd_data = the write value.
  - Otherwise rd_data = the stored value.
- rd_busy, per port k:
  - busy[rd_addr], except when BYPASS and a LOAD write-back to that address occurs this cycle; then 0.
  - A same-cycle ld_issue does not affect rd_busy until the next cycle.

## Timing
- Reset (reset_n low, asynchronous): all registers 0, all busy bits 0, sb_err 0. rd_data and rd_busy follow combinationally, so they read 0 after reset.
- Write latency: stored value is visible 1 cycle after the write. With BYPASS = 1 it is also visible in the same cycle.
- Scoreboard latency: busy is visible on rd_busy the cycle after ld_issue. It clears in the write-back cycle with BYPASS = 1, and the following cycle with BYPASS = 0.
- sb_err asserts the cycle after the offending write-back, for exactly 1 cycle.
- Reset mid-operation clears all outstanding busy bits. A later return of a pre-reset load commits and pulses sb_err.
- Read ports are fully independent; any number of ports may read the same address.

## Test plan
- Reset: load r5 = 0x0801_8005, assert reset_n = 0 asynchronously mid-cycle -> rd_data = 0 for r5 immediately; sb_err = 0; all rd_busy = 0.
- Write sources: write to r1 with ALU 0x1234_5678, to r2 with LUI 0xABCD_E000, to r3 with LINK 0x0000_0104 -> next-cycle reads return exactly those values. Write 0xFFFF_FFFF to x0 -> x0 still reads 0.
- Load extraction with wr_load = 0x80FF_7F01:
  - byte, off 3, signed -> 0xFFFF_FF80.
  - byte, off 2, unsigned -> 0x0000_00FF.
  - half, off 2, signed -> 0xFFFF_80FF.
  - half, off 1 -> same as off 0 = 0x0000_7F01.
  - word -> 0x80FF_7F01.
- Scoreboard:
  - ld_issue r7 -> rd_busy on r7 = 1 from the next cycle.
  - LOAD write-back to r7 -> rd_busy = 0 in the same cycle (BYPASS = 1) and rd_data = the loaded value.
  - Simultaneous issue and return on r7 -> r7 stays busy.
- Bypass off (BYPASS = 0): write 0x55 to r4 while port 1 reads r4 -> port 1 returns the old value that cycle and 0x55 the next.
- Error path: LOAD write-back to non-busy r9 -> write commits and sb_err = 1 for exactly one cycle. ALU write to busy r9 -> r9 stays busy and sb_err = 0.
